register_file_mp: RTL and testbench
===================================

// Module: register_file_mp
// PURPOSE
//   Multi-port integer register file with write-to-read bypass and a per-register pending-write scoreboard.
//   Next-generation replacement for the single-write-port file, sized for dual-issue / multi-writeback pipelines.
//   Sits in decode: read ports feed operand fetch; write ports are driven from writeback.
//   The claim/busy interface gives the hazard unit register-level RAW stall information.
// PARAMETERS
//   DataWidth      32   width of each register
//   NumRegisters   32   register count incl. x0; AddrWidth = $clog2(NumRegisters)
//   NumReadPorts   2    independent combinational read ports (>=1)
//   NumWritePorts  2    synchronous write ports (>=1); higher index = higher priority
//   Bypass         1    1: same-cycle write data forwarded to reads; 0: reads return stored value
//   SpIndex        2    register loaded with SpInitValue on reset
//   SpInitValue    255  reset value of register SpIndex (all others reset to 0)
// PORTS
//   clk          in   1                              clock, all state updates on posedge
//   rst          in   1                              synchronous, active-high reset
//   rd_addr      in   [NumReadPorts][AddrWidth]      read addresses
//   rd_data      out  [NumReadPorts][DataWidth]      read data, combinational
//   rd_busy      out  [NumReadPorts]                 register has an outstanding claimed write
//   wr_en        in   [NumWritePorts]                write strobes
//   wr_addr      in   [NumWritePorts][AddrWidth]     write addresses
//   wr_data      in   [NumWritePorts][DataWidth]     write data
//   claim_en     in   1                              mark claim_addr as pending (instruction issued)
//   claim_addr   in   AddrWidth                      destination register being claimed
//   flush        in   1                              clear all pending bits (pipeline squash)
// BEHAVIOUR
//   - Reset (posedge clk with rst=1): mem=0 except mem[SpIndex]=SpInitValue; pending=0.
//     rst overrides every write, claim and flush in the same cycle.
//     From the following cycle: rd_data=0 (SpInitValue at SpIndex) and rd_busy=0.
//   - x0: reads always 0. rd_busy always 0. Writes and claims to x0 are ignored.
//   - Read: rd_data[i]=mem[rd_addr[i]], zero latency.
//     With Bypass=1, if any wr_en[j] && wr_addr[j]==rd_addr[i]!=0, rd_data[i]=wr_data[j] of the highest such j.
//   - Write: on posedge, mem[wr_addr[j]] <= wr_data[j] for each enabled j.
//     If several ports target the same address, the highest index wins.
//   - Scoreboard: pending[NumRegisters] flags.
//     Next-state per register r, in order:
//       (1) flush clears all;
//       (2) an enabled write to r clears pending[r];
//       (3) claim_en with claim_addr==r sets pending[r].
//     Claim beats write and flush in the same cycle, so the newer producer stays tracked.
//   - rd_busy[i]=pending[rd_addr[i]] && rd_addr[i]!=0.
//     With Bypass=1, rd_busy is additionally masked when a same-cycle write to that address exists.
//     Bypass=0 never masks.
//   - Writes to non-pending registers are legal; pending is unaffected beyond rule (2).
//   - Addresses >= NumRegisters (non-power-of-2 sizes): reads return 0, writes and claims ignored.
//   - No internal handshakes, no stalls; the block never back-pressures.
// TESTING
//   1. Reset: rst 1 cycle -> all 32 rd reads 0 except x2=255; all rd_busy=0.
//   2. Write x5=0xDEAD_BEEF on port0; same cycle read x5 -> 0xDEADBEEF with Bypass=1, old value with Bypass=0.
//      Next cycle -> 0xDEADBEEF for both.
//   3. Both ports write x7 (p0=0x11, p1=0x22) -> x7 reads 0x22.
//      Write x0=0x55 -> x0 reads 0, busy 0.
//   4. Claim x9 -> rd_busy=1 next cycle. Write x9=0x33 -> busy 0 after the edge (same-cycle masked if Bypass=1).
//      Claim and write x9 in the same cycle -> busy stays 1.
//   5. Claim x3,x4,x6 over 3 cycles, then flush -> all busy 0.
//      Flush together with claim x8 -> only x8 busy.
//   6. Mid-stream: pending x3 and writes in flight, assert rst -> contents, pending and sp restored per test 1.

Source files
------------

// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - multi-port register file with write-to-read bypass and pending-write scoreboard
module register_file_mp #(
  parameter int                      DataWidth     = 32,
  parameter int                      NumRegisters  = 32,
  parameter int                      NumReadPorts  = 2,
  parameter int                      NumWritePorts = 2,
  parameter int                      Bypass        = 1,
  parameter int                      SpIndex       = 2,
  parameter logic [DataWidth-1:0]    SpInitValue   = 'd255,
  localparam int                     AddrWidth     = (NumRegisters > 1) ? $clog2(NumRegisters) : 1
) (
  input  logic                                         i_clk,
  input  logic                                         i_rst,
  input  logic [NumReadPorts-1:0][AddrWidth-1:0]       i_rd_addr,
  output logic [NumReadPorts-1:0][DataWidth-1:0]       o_rd_data,
  output logic [NumReadPorts-1:0]                      o_rd_busy,
  input  logic [NumWritePorts-1:0]                     i_wr_en,
  input  logic [NumWritePorts-1:0][AddrWidth-1:0]      i_wr_addr,
  input  logic [NumWritePorts-1:0][DataWidth-1:0]      i_wr_data,
  input  logic                                         i_claim_en,
  input  logic [AddrWidth-1:0]                         i_claim_addr,
  input  logic                                         i_flush
);

  // Register storage; entry 0 is never written so it stays zero.
  logic [DataWidth-1:0]    r_mem [NumRegisters];
  // One flag per register: a claimed producer has not yet written back.
  logic [NumRegisters-1:0] r_pending;

  // Next-state of the scoreboard, computed combinationally.
  logic [NumRegisters-1:0] w_pending_next;

  // Per read port: does a same-cycle write target this address, and with what data.
  logic [NumReadPorts-1:0]                w_rd_hit;
  logic [NumReadPorts-1:0][DataWidth-1:0] w_rd_fwd;
  logic [NumReadPorts-1:0]                w_rd_ok;

  // An address is usable when it is not x0 and lies inside the implemented range.
  function automatic logic f_addr_ok(input logic [AddrWidth-1:0] a);
    return (a != '0) && (int'(a) < NumRegisters);
  endfunction

  // Storage update: reset image, else in-order port writes so the highest port wins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int r = 0; r < NumRegisters; r++) begin
        r_mem[r] <= (r == SpIndex) ? SpInitValue : '0;
      end
    end else begin
      for (int j = 0; j < NumWritePorts; j++) begin
        if (i_wr_en[j] && f_addr_ok(i_wr_addr[j])) begin
          r_mem[i_wr_addr[j]] <= i_wr_data[j];
        end
      end
    end
  end

  // Scoreboard next state: flush, then writeback clears, then the claim sets (newest producer wins).
  always_comb begin
    w_pending_next = i_flush ? '0 : r_pending;
    for (int j = 0; j < NumWritePorts; j++) begin
      if (i_wr_en[j] && f_addr_ok(i_wr_addr[j])) begin
        w_pending_next[i_wr_addr[j]] = 1'b0;
      end
    end
    if (i_claim_en && f_addr_ok(i_claim_addr)) begin
      w_pending_next[i_claim_addr] = 1'b1;
    end
  end

  // Scoreboard register; reset overrides flush, claim and writeback.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_next;
    end
  end

  // Same-cycle write detection per read port; later ports overwrite earlier so the highest index wins.
  always_comb begin
    w_rd_hit = '0;
    w_rd_fwd = '0;
    w_rd_ok  = '0;
    for (int i = 0; i < NumReadPorts; i++) begin
      w_rd_ok[i] = f_addr_ok(i_rd_addr[i]);
      for (int j = 0; j < NumWritePorts; j++) begin
        if (i_wr_en[j] && (i_wr_addr[j] == i_rd_addr[i])) begin
          w_rd_hit[i] = 1'b1;
          w_rd_fwd[i] = i_wr_data[j];
        end
      end
    end
  end

  // Read data and busy: x0 and out-of-range addresses read as zero and never busy.
  always_comb begin
    o_rd_data = '0;
    o_rd_busy = '0;
    for (int i = 0; i < NumReadPorts; i++) begin
      if (w_rd_ok[i]) begin
        if ((Bypass != 0) && w_rd_hit[i]) begin
          o_rd_data[i] = w_rd_fwd[i];
          o_rd_busy[i] = 1'b0;
        end else begin
          o_rd_data[i] = r_mem[i_rd_addr[i]];
          o_rd_busy[i] = r_pending[i_rd_addr[i]];
        end
      end
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// tb/tb_register_file_mp.sv - table-driven scoreboard bench for register_file_mp
module tb_register_file_mp;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0][4:0] rd_addr;
  logic [1:0][31:0] rd_data, rd_data_nb;
  logic [1:0]      rd_busy, rd_busy_nb;
  logic [1:0]      wr_en;
  logic [1:0][4:0] wr_addr;
  logic [1:0][31:0] wr_data;
  logic            claim_en;
  logic [4:0]      claim_addr;
  logic            flush;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  register_file_mp #(.Bypass(1)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_busy(rd_busy),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_claim_en(claim_en), .i_claim_addr(claim_addr), .i_flush(flush)
  );

  register_file_mp #(.Bypass(0)) u_dut_nb (
    .i_clk(clk), .i_rst(rst), .i_rd_addr(rd_addr), .o_rd_data(rd_data_nb), .o_rd_busy(rd_busy_nb),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_claim_en(claim_en), .i_claim_addr(claim_addr), .i_flush(flush)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        ce;
    logic [4:0]  ca;
    logic        fl;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] ed0;
    logic [31:0] ed1;
    logic [1:0]  eb;
    logic [31:0] ed_nb;
    logic        eb_nb;
  } vec_t;

  vec_t sbq[$];
  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [1:0] we,
                              input logic [4:0] wa0, input logic [31:0] wd0,
                              input logic [4:0] wa1, input logic [31:0] wd1,
                              input logic ce, input logic [4:0] ca, input logic fl,
                              input logic [4:0] ra0, input logic [4:0] ra1,
                              input logic [31:0] ed0, input logic [31:0] ed1, input logic [1:0] eb,
                              input logic [31:0] ed_nb, input logic eb_nb);
    vec_t v;
    v.rst = r; v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.ce = ce; v.ca = ca; v.fl = fl; v.ra0 = ra0; v.ra1 = ra1;
    v.ed0 = ed0; v.ed1 = ed1; v.eb = eb; v.ed_nb = ed_nb; v.eb_nb = eb_nb;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%08h, expected 0x%08h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge, compare mid-cycle before the rising edge.
  task automatic drive(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    rst = v.rst; wr_en = v.we;
    wr_addr[0] = v.wa0; wr_data[0] = v.wd0;
    wr_addr[1] = v.wa1; wr_data[1] = v.wd1;
    claim_en = v.ce; claim_addr = v.ca; flush = v.fl;
    rd_addr[0] = v.ra0; rd_addr[1] = v.ra1;
    sbq.push_back(v);
    #1;
    e = sbq.pop_front();
    chk("rd_data0", idx, rd_data[0], e.ed0);
    chk("rd_data1", idx, rd_data[1], e.ed1);
    chk("rd_busy", idx, {30'd0, rd_busy}, {30'd0, e.eb});
    chk("nb_rd_data0", idx, rd_data_nb[0], e.ed_nb);
    chk("nb_rd_busy0", idx, {31'd0, rd_busy_nb[0]}, {31'd0, e.eb_nb});
  endtask

  // Idle cycles reading every register on both ports; checks the reset image.
  task automatic reset_sweep(input int base);
    for (int a = 0; a < 32; a++) begin
      logic [4:0]  a0, a1;
      logic [31:0] e0, e1;
      a0 = 5'(a);
      a1 = 5'(31 - a);
      e0 = (a == 2) ? 32'd255 : 32'd0;
      e1 = (31 - a == 2) ? 32'd255 : 32'd0;
      drive(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, a0, a1, e0, e1, 2'b00, e0, 1'b0), base + a);
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0;
    claim_en = 1'b0; claim_addr = '0; flush = 1'b0; rd_addr = '0;

    //           rst we     wa0 wd0            wa1 wd1    ce ca fl ra0 ra1 ed0            ed1            eb     ed_nb          eb_nb
    vecs.push_back(mk(0, 2'b01, 5, 32'hDEADBEEF, 0, 0,     0, 0, 0, 5, 2,  32'hDEADBEEF, 32'd255,       2'b00, 32'h0,         0));
    vecs.push_back(mk(0, 2'b00, 0, 0,            0, 0,     0, 0, 0, 5, 0,  32'hDEADBEEF, 32'h0,         2'b00, 32'hDEADBEEF,  0));
    vecs.push_back(mk(0, 2'b11, 7, 32'h11,       7, 32'h22,0, 0, 0, 7, 7,  32'h22,       32'h22,        2'b00, 32'h0,         0));
    vecs.push_back(mk(0, 2'b00, 0, 0,            0, 0,     0, 0, 0, 7, 5,  32'h22,       32'hDEADBEEF,  2'b00, 32'h22,        0));
    vecs.push_back(mk(0, 2'b01, 0, 32'h55,       0, 0,     0, 0, 0, 0, 0,  32'h0,        32'h0,         2'b00, 32'h0,         0));
    vecs.push_back(mk(0, 2'b00, 0, 0,            0, 0,     0, 0, 0, 0, 7,  32'h0,        32'h22,        2'b00, 32'h0,         0));
    vecs.push_back(mk(0, 2'b00, 0, 0,            0, 0,     1, 9, 0, 9, 9,  32'h0,        32'h0,         2'b00, 32'h0,         0));
    vecs.push_back(mk(0, 2'b00, 0, 0,            0, 0,     0, 0, 0, 9, 9,  32'h0,        32'h0,         2'b11, 32'h0,         1));
    vecs.push_back(mk(0, 2'b10, 0, 0,            9, 32'h33,0, 0, 0, 9, 9,  32'h33,       32'h33,        2'b00, 32'h0,         1));
    vecs.push_back(mk(0, 2'b00, 0, 0,            0, 0,     0, 0, 0, 9, 9,  32'h33,       32'h33,        2'b00, 32'h33,        0));
    vecs.push_back(mk(0, 2'b01, 9, 32'h44,       0, 0,     1, 9, 0, 9, 9,  32'h44,       32'h44,        2'b00, 32'h33,        0));
    vecs.push_back(mk(0, 2'b00, 0, 0,            0, 0,     0, 0, 0, 9, 9,  32'h44,       32'h44,        2'b11, 32'h44,        1));
    vecs.push_back(mk(0, 2'b01, 9, 32'h45,       0, 0,     0, 0, 0, 9, 3,  32'h45,       32'h0,         2'b00, 32'h44,        1));
    vecs.push_back(mk(0, 2'b00, 0, 0,            0, 0,     1, 3, 0, 3, 4,  32'h0,        32'h0,         2'b00, 32'h0,         0));
    vecs.push_back(mk(0, 2'b00, 0, 0,            0, 0,     1, 4, 0, 3, 4,  32'h0,        32'h0,         2'b01, 32'h0,         1));
    vecs.push_back(mk(0, 2'b00, 0, 0,            0, 0,     1, 6, 0, 4, 6,  32'h0,        32'h0,         2'b01, 32'h0,         1));
    vecs.push_back(mk(0, 2'b00, 0, 0,            0, 0,     0, 0, 1, 3, 6,  32'h0,        32'h0,         2'b11, 32'h0,         1));
    vecs.push_back(mk(0, 2'b00, 0, 0,            0, 0,     0, 0, 0, 3, 6,  32'h0,        32'h0,         2'b00, 32'h0,         0));
    vecs.push_back(mk(0, 2'b00, 0, 0,            0, 0,     0, 0, 0, 4, 9,  32'h0,        32'h45,        2'b00, 32'h0,         0));
    vecs.push_back(mk(0, 2'b00, 0, 0,            0, 0,     1, 8, 1, 8, 3,  32'h0,        32'h0,         2'b00, 32'h0,         0));
    vecs.push_back(mk(0, 2'b00, 0, 0,            0, 0,     0, 0, 0, 8, 3,  32'h0,        32'h0,         2'b01, 32'h0,         1));
    vecs.push_back(mk(0, 2'b00, 0, 0,            0, 0,     0, 0, 0, 4, 6,  32'h0,        32'h0,         2'b00, 32'h0,         0));
    vecs.push_back(mk(0, 2'b11, 10, 32'h77,      11, 32'h88,1, 3, 0, 10, 11, 32'h77,      32'h88,        2'b00, 32'h0,         0));
    vecs.push_back(mk(1, 2'b01, 5, 32'h99,       0, 0,     1, 12, 0, 3, 10, 32'h0,       32'h77,        2'b01, 32'h0,         1));

    repeat (2) @(posedge clk);
    reset_sweep(0);
    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k], 100 + k);
    end
    reset_sweep(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
